uart_rle_encoder: RTL and testbench

Run-length encoder placed directly downstream of the UART receiver. Each received byte is a single-cycle `in_valid` strobe driven by the receiver's `data_ready`, with `in_data` driven by the receiver's `data_out`. The block compresses runs of identical bytes into (count, value) byte pairs and buffers them in an internal FIFO. The FIFO drains through a valid/ready byte interface toward the UART transmitter path.

---
 rtl/uart_rle_encoder.sv | 155 +++++++++++++++
 tb/tb_uart_rle_encoder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rle_encoder.sv
// uart_rle_encoder
// Run-length encoder sitting behind the UART receiver. Runs of identical
// bytes are compressed into (count, value) byte pairs. The pairs are queued in
// an output FIFO that drains through a valid/ready byte interface.
//
// state | meaning
// ------+-----------------------------------------------------------
// EMPTY | no run in progress, nothing to emit on flush
// RUN   | cur_val/cur_cnt hold an open run that has not been pushed
//
// Ports:
//   clk_100MHz  in   system clock, rising edge
//   reset       in   asynchronous, active-high
//   in_valid    in   one-cycle strobe, new input byte on in_data
//   in_data     in   input byte
//   flush       in   end-of-stream request, emits the pending run
//   tx_ready    in   downstream accepts tx_data this cycle
//   tx_valid    out  FIFO non-empty
//   tx_data     out  FIFO head byte
//   fifo_level  out  bytes stored, 0..FIFO_DEPTH
//   overflow    out  sticky, set when a pair is dropped for lack of space
module uart_rle_encoder #(
    parameter int MAX_RUN    = 255,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_100MHz,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    input  logic                          flush,
    input  logic                          tx_ready,
    output logic                          tx_valid,
    output logic [7:0]                    tx_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [7:0]       MAX_CNT    = 8'(MAX_RUN);
    // A push writes two bytes, so it needs the level to be at most DEPTH-2.
    localparam logic [LVL_W-1:0] PUSH_LIMIT = LVL_W'(FIFO_DEPTH - 2);

    typedef enum logic {
        EMPTY = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [7:0]       cur_val, cur_val_next;
    logic [7:0]       cur_cnt, cur_cnt_next;
    logic             flush_pend, flush_pend_next;
    logic             push_req;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level;
    logic             space_ok, push, pop;

    // ------------------------------------------------------------------
    // Run tracking FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            cur_val    <= 8'h00;
            cur_cnt    <= 8'h00;
            flush_pend <= 1'b0;
        end else begin
            state      <= state_next;
            cur_val    <= cur_val_next;
            cur_cnt    <= cur_cnt_next;
            flush_pend <= flush_pend_next;
        end
    end

    always_comb begin
        state_next      = state;
        cur_val_next    = cur_val;
        cur_cnt_next    = cur_cnt;
        push_req        = 1'b0;
        // A flush arriving together with a byte stays pending and is
        // serviced on the next idle cycle.
        flush_pend_next = flush_pend | flush;

        if (in_valid) begin
            unique case (state)
                EMPTY: begin
                    cur_val_next = in_data;
                    cur_cnt_next = 8'd1;
                    state_next   = RUN;
                end
                RUN: begin
                    if ((in_data == cur_val) && (cur_cnt < MAX_CNT)) begin
                        cur_cnt_next = cur_cnt + 8'd1;
                    end else begin
                        push_req     = 1'b1;
                        cur_val_next = in_data;
                        cur_cnt_next = 8'd1;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end else if (flush_pend | flush) begin
            flush_pend_next = 1'b0;
            if (state == RUN) begin
                push_req   = 1'b1;
                state_next = EMPTY;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO. Admission uses the level at the start of the cycle; a
    // same-cycle pop does not make room. A refused push still lets the run
    // state advance, the pair is simply lost.
    // ------------------------------------------------------------------
    assign space_ok   = (level <= PUSH_LIMIT);
    assign push       = push_req & space_ok;
    assign tx_valid   = (level != '0);
    assign pop        = tx_valid & tx_ready;
    assign tx_data    = mem[rd_ptr];
    assign fifo_level = level;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr]               <= cur_cnt;
                mem[wr_ptr + PTR_W'(1)]   <= cur_val;
                wr_ptr                    <= wr_ptr + PTR_W'(2);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(2);
                2'b11:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            if (push_req && !space_ok) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rle_encoder.sv
// Self-checking bench for uart_rle_encoder (MAX_RUN=255, FIFO_DEPTH=16).
// Expected output bytes come from a run-length reference encoder working on
// whole input byte streams; every popped byte is compared against it.
module tb_uart_rle_encoder;

    typedef logic [7:0] bq_t [$];

    logic       clk_100MHz = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       flush;
    logic       tx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic [4:0] fifo_level;
    logic       overflow;

    int  n_pass  = 0;
    int  n_total = 0;
    int  n_popped = 0;
    bq_t exp_q;

    uart_rle_encoder #(.MAX_RUN(255), .FIFO_DEPTH(16)) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .flush      (flush),
        .tx_ready   (tx_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: split the stream into maximal runs of at most 255 bytes.
    function automatic void model_encode(input bq_t d);
        int i = 0;
        while (i < d.size()) begin
            logic [7:0] v = d[i];
            int n = 1;
            while ((i + n < d.size()) && (d[i + n] == v) && (n < 255)) n++;
            exp_q.push_back(8'(n));
            exp_q.push_back(v);
            i += n;
        end
    endfunction

    // Called just after a falling edge with inputs already set. Outputs are
    // stable here, and a pop happens at the next rising edge.
    task automatic tick();
        if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_pop_level", 32'(fifo_level), 32'd0);
            end else begin
                logic [7:0] e = exp_q.pop_front();
                check("tx_data", 32'(tx_data), 32'(e));
            end
            n_popped++;
        end
        @(negedge clk_100MHz);
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        tx_ready = 1'b1;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        check("drain_complete", 32'(exp_q.size()), 32'd0);
        check("drain_tx_valid", 32'(tx_valid), 32'd0);
        check("drain_level", 32'(fifo_level), 32'd0);
    endtask

    initial begin
        bq_t        d;
        logic [7:0] v, prev;
        int         idx, len, popped0, k;

        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; flush = 1'b0; tx_ready = 1'b0;
        repeat (3) @(negedge clk_100MHz);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        reset = 1'b0;
        @(negedge clk_100MHz);

        // Basic runs
        d = '{8'h41, 8'h41, 8'h41, 8'h42};
        model_encode(d);
        tx_ready = 1'b1;
        foreach (d[i]) send(d[i]);
        do_flush();
        drain(20);
        check("basic_overflow", 32'(overflow), 32'd0);
        check("basic_pop_count", 32'(n_popped), 32'd4);

        // Flush latency: count at N+1, value one cycle after the first pop
        tx_ready = 1'b0;
        send(8'h77);
        check("lat_no_push_yet", 32'(fifo_level), 32'd0);
        exp_q.push_back(8'h01); exp_q.push_back(8'h77);
        do_flush();
        check("lat_count_valid", 32'(tx_valid), 32'd1);
        check("lat_count_data", 32'(tx_data), 32'h01);
        tx_ready = 1'b1;
        tick();
        check("lat_value_data", 32'(tx_data), 32'h77);
        drain(5);

        // Run limit
        d.delete();
        for (int i = 0; i < 256; i++) d.push_back(8'h00);
        model_encode(d);
        foreach (d[i]) send(d[i]);
        do_flush();
        drain(20);

        // Simultaneous byte + flush, then push with pop
        tx_ready = 1'b0;
        exp_q.push_back(8'h03); exp_q.push_back(8'h55);
        exp_q.push_back(8'h01); exp_q.push_back(8'h66);
        exp_q.push_back(8'h01); exp_q.push_back(8'h67);
        send(8'h55); send(8'h55);
        in_valid = 1'b1; in_data = 8'h55; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        check("simul_not_early", 32'(fifo_level), 32'd0);
        tick();
        check("simul_level", 32'(fifo_level), 32'd2);
        check("simul_count", 32'(tx_data), 32'h03);
        send(8'h66);
        check("simul_run_level", 32'(fifo_level), 32'd2);
        tx_ready = 1'b1;
        send(8'h67);
        check("push_pop_level", 32'(fifo_level), 32'd3);
        do_flush();
        drain(20);

        // Backpressure and overflow
        tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) send((i % 2 == 0) ? 8'h10 : 8'h20);
        do_flush();
        check("ovf_level", 32'(fifo_level), 32'd16);
        check("ovf_flag", 32'(overflow), 32'd1);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'h01);
            exp_q.push_back((i % 2 == 0) ? 8'h10 : 8'h20);
        end
        popped0 = n_popped;
        drain(40);
        check("ovf_drain_count", 32'(n_popped - popped0), 32'd16);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Reset mid-operation: 6 bytes queued plus an open run
        tx_ready = 1'b0;
        send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h04);
        check("mid_level", 32'(fifo_level), 32'd6);
        reset = 1'b1;
        #1;
        check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        check("mid_rst_tx_data", 32'(tx_data), 32'd0);
        exp_q.delete();
        @(negedge clk_100MHz);
        reset = 1'b0;
        tx_ready = 1'b1;
        do_flush();
        for (int i = 0; i < 4; i++) begin
            check("post_rst_silent", 32'(tx_valid), 32'd0);
            tick();
        end
        check("post_rst_level", 32'(fifo_level), 32'd0);

        // Pointer wrap: 40 random runs, random tx_ready, never overflow
        d.delete();
        prev = 8'h00;
        for (int r = 0; r < 40; r++) begin
            v = 8'($urandom_range(0, 255));
            if (r != 0 && v == prev) v = v + 8'd1;
            len = $urandom_range(1, 4);
            for (int j = 0; j < len; j++) d.push_back(v);
            prev = v;
        end
        model_encode(d);
        popped0 = n_popped;
        idx = 0;
        k = 0;
        while (idx < d.size() && k < 5000) begin
            tx_ready = 1'($urandom_range(0, 1));
            if (fifo_level <= 5'd14 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_data  = d[idx];
                idx++;
            end
            tick();
            in_valid = 1'b0;
            k++;
        end
        check("wrap_all_sent", 32'(idx), 32'(d.size()));
        tx_ready = 1'b1;
        k = 0;
        while (fifo_level > 5'd14 && k < 20) begin
            tick();
            k++;
        end
        do_flush();
        drain(200);
        check("wrap_pop_count", 32'(n_popped - popped0), 32'd80);
        check("wrap_overflow", 32'(overflow), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
